lcu_cond_conditioner: RTL

LCU_COND_CONDITIONER -- requirements
Module: lcu_cond_conditioner

---
 rtl/lcu_cond_conditioner.sv | 89 ++++++++
 1 files changed

// File: rtl/lcu_cond_conditioner.sv
// ============================================================================
// lcu_cond_conditioner : synchronizes, debounces and glitch-counts the 15
//                        controller condition inputs x1..x15.
// Revision: 1.0  initial release
// ============================================================================
`default_nettype none

module lcu_cond_conditioner #(
  parameter int          DEB_CYCLES = 4,
  parameter logic [14:0] RESET_X    = 15'h0000
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [14:0] raw_x,
  input  logic        hold,
  input  logic        glitch_clr,
  output logic [14:0] x_out,
  output logic        x_chg,
  output logic        stable,
  output logic [7:0]  glitch_cnt
);

  localparam logic [3:0] C_DEB_MAX = 4'(DEB_CYCLES - 1);

  logic [14:0]      s1_q, s1_d;
  logic [14:0]      s2_q, s2_d;
  logic [14:0]      x_q, x_d;
  logic [14:0][3:0] cnt_q, cnt_d;
  logic [7:0]       glitch_q, glitch_d;
  logic             chg_q, chg_d;
  logic             any_glitch;

  always_comb begin
    s1_d       = raw_x;
    s2_d       = s1_q;
    x_d        = x_q;
    cnt_d      = cnt_q;
    any_glitch = 1'b0;
    for (int i = 0; i < 15; i++) begin
      if (s2_q[i] == x_q[i]) begin
        // Agreement after a partial run means the input bounced back.
        cnt_d[i] = 4'd0;
        if (cnt_q[i] != 4'd0) any_glitch = 1'b1;
      end else if (cnt_q[i] < C_DEB_MAX) begin
        cnt_d[i] = cnt_q[i] + 4'd1;
      end else if (!hold) begin
        x_d[i]   = s2_q[i];
        cnt_d[i] = 4'd0;
      end else begin
        cnt_d[i] = C_DEB_MAX;
      end
    end

    chg_d = |(x_d ^ x_q);

    if (glitch_clr)
      glitch_d = 8'd0;
    else if (any_glitch && (glitch_q != 8'hFF))
      glitch_d = glitch_q + 8'd1;
    else
      glitch_d = glitch_q;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      s1_q     <= RESET_X;
      s2_q     <= RESET_X;
      x_q      <= RESET_X;
      cnt_q    <= '0;
      glitch_q <= 8'd0;
      chg_q    <= 1'b0;
    end else begin
      s1_q     <= s1_d;
      s2_q     <= s2_d;
      x_q      <= x_d;
      cnt_q    <= cnt_d;
      glitch_q <= glitch_d;
      chg_q    <= chg_d;
    end
  end

  assign x_out      = x_q;
  assign x_chg      = chg_q;
  assign glitch_cnt = glitch_q;
  assign stable     = (s2_q == x_q);

endmodule

`default_nettype wire
